// File: rtl/fir_pkg.sv
// Shared register map, control/status bit positions and output conversion helper for the FIR engine.
// FIR_SATURATE_EN (defined in the datapath build) selects sat_to_32 instead of plain truncation.
package fir_pkg;

  localparam int MAX_TAPS_DEFAULT = 16;

  localparam logic [31:0] ADDR_CONTROL   = 32'h0000_0000;
  localparam logic [31:0] ADDR_TAP_COUNT = 32'h0000_0008;
  localparam logic [31:0] ADDR_COEFF     = 32'h0000_000C;
  localparam logic [31:0] ADDR_X         = 32'h0000_0010;

  localparam int CTRL_COMPUTE    = 0;
  localparam int CTRL_LOAD_START = 1;

  localparam int STAT_LOADED  = 0;
  localparam int STAT_READY   = 1;
  localparam int STAT_COMPUTE = 2;

  localparam logic signed [63:0] S32_MAX = 64'sd2147483647;
  localparam logic signed [63:0] S32_MIN = -64'sd2147483648;

  function automatic logic [31:0] sat_to_32(input logic signed [63:0] acc);
    if (acc > S32_MAX) return 32'h7FFF_FFFF;
    else if (acc < S32_MIN) return 32'h8000_0000;
    else return acc[31:0];
  endfunction

endpackage

// File: rtl/fir_datapath.sv
// Coefficient store, sample delay line and multiply-accumulate for the FIR engine.
// FIR_SATURATE_EN: saturate the 64-bit sum to signed 32 bits; otherwise keep the low 32 bits.
module fir_datapath
  import fir_pkg::*;
#(
  parameter int MAX_TAPS = MAX_TAPS_DEFAULT,
  parameter int TW       = $clog2(MAX_TAPS + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [TW-1:0] tap_count,
  input  logic          load_restart,
  input  logic          coeff_data_valid,
  input  logic [31:0]   coeff_data,
  input  logic          compute,
  input  logic          input_data_valid,
  input  logic [31:0]   input_data,
  output logic [31:0]   output_data,
  output logic          output_data_valid,
  output logic          coefficient_loading_complete
);

  localparam int IW = $clog2(MAX_TAPS);

  logic signed [31:0] coeff [MAX_TAPS];
  logic signed [31:0] delay [MAX_TAPS];
  logic [TW-1:0]      coeff_idx;
  logic               mac_pending;
  logic               shift_en;
  logic signed [63:0] acc;
  logic [31:0]        result;

  assign shift_en = input_data_valid & compute & coefficient_loading_complete;

  always_comb begin
    acc = '0;
    for (int i = 0; i < MAX_TAPS; i++) begin
      if (TW'(i) < tap_count) acc = acc + 64'(coeff[i]) * 64'(delay[i]);
    end
  end

`ifdef FIR_SATURATE_EN
  assign result = sat_to_32(acc);
`else
  logic unused_acc_hi;
  assign result        = acc[31:0];
  assign unused_acc_hi = ^acc[63:32];
`endif

  // The sum is formed one cycle after the shift so it sees the updated delay line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MAX_TAPS; i++) begin
        coeff[i] <= '0;
        delay[i] <= '0;
      end
      coeff_idx                    <= '0;
      coefficient_loading_complete <= 1'b0;
      mac_pending                  <= 1'b0;
      output_data                  <= '0;
      output_data_valid            <= 1'b0;
    end else begin
      mac_pending       <= shift_en;
      output_data_valid <= mac_pending;
      if (mac_pending) output_data <= result;

      if (load_restart) begin
        coeff_idx                    <= '0;
        coefficient_loading_complete <= 1'b0;
      end else if (coeff_data_valid && !coefficient_loading_complete) begin
        coeff[coeff_idx[IW-1:0]] <= coeff_data;
        coeff_idx                <= coeff_idx + TW'(1);
        if (coeff_idx + TW'(1) == tap_count) coefficient_loading_complete <= 1'b1;
      end

      if (shift_en) begin
        delay[0] <= input_data;
        for (int i = 1; i < MAX_TAPS; i++) delay[i] <= delay[i-1];
      end
    end
  end

endmodule

// File: rtl/fir_control_unit.sv
// Memory-mapped FIR engine: snoops AXI-Lite write addresses, decodes register writes and feeds fir_datapath.
// FIR_SATURATE_EN (seen by fir_datapath) switches the output from wrapping to saturating.
module fir_control_unit
  import fir_pkg::*;
#(
  parameter int MAX_TAPS = MAX_TAPS_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] control_axi,
  input  logic [31:0] tap_count_axi,
  input  logic [31:0] coeff_axi,
  input  logic [31:0] x_axi,
  output logic [31:0] status_axi,
  output logic [31:0] y_axi,
  input  logic        S_AXI_AWREADY,
  input  logic        S_AXI_AWVALID,
  input  logic [31:0] S_AXI_AWADDR
);

  localparam int TW = $clog2(MAX_TAPS + 1);

  logic          wr_pending;
  logic [31:0]   wr_addr;
  logic          hit_control, hit_taps, hit_coeff, hit_x;
  logic [TW-1:0] tap_count, tap_clamped;
  logic          compute, ready;
  logic          load_restart, coeff_valid, x_valid;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          loaded;
  logic          unused_ctrl;

  assign unused_ctrl = ^control_axi[31:2];

  // The address is captured on the handshake edge; the register value is taken one edge later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_pending <= 1'b0;
      wr_addr    <= '0;
    end else begin
      wr_pending <= S_AXI_AWVALID & S_AXI_AWREADY;
      if (S_AXI_AWVALID && S_AXI_AWREADY) wr_addr <= S_AXI_AWADDR;
    end
  end

  assign hit_control = wr_pending && (wr_addr == ADDR_CONTROL);
  assign hit_taps    = wr_pending && (wr_addr == ADDR_TAP_COUNT);
  assign hit_coeff   = wr_pending && (wr_addr == ADDR_COEFF);
  assign hit_x       = wr_pending && (wr_addr == ADDR_X);

  always_comb begin
    tap_clamped = tap_count_axi[TW-1:0];
    if (tap_count_axi == 32'd0) tap_clamped = TW'(1);
    else if (tap_count_axi > 32'(MAX_TAPS)) tap_clamped = TW'(MAX_TAPS);
  end

  assign load_restart = hit_taps | (hit_control & control_axi[CTRL_LOAD_START]);
  assign coeff_valid  = hit_coeff & ~loaded;
  assign x_valid      = hit_x & compute & loaded;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tap_count <= '0;
      compute   <= 1'b0;
      ready     <= 1'b0;
      y_axi     <= '0;
    end else begin
      if (hit_taps) tap_count <= tap_clamped;
      if (hit_control) compute <= control_axi[CTRL_COMPUTE];
      if (x_valid) ready <= 1'b0;
      else if (out_valid) ready <= 1'b1;
      if (out_valid) y_axi <= out_data;
    end
  end

  always_comb begin
    status_axi               = '0;
    status_axi[STAT_LOADED]  = loaded;
    status_axi[STAT_READY]   = ready;
    status_axi[STAT_COMPUTE] = compute;
  end

  fir_datapath #(
    .MAX_TAPS (MAX_TAPS),
    .TW       (TW)
  ) u_datapath (
    .clk                          (clk),
    .rstn                         (rstn),
    .tap_count                    (tap_count),
    .load_restart                 (load_restart),
    .coeff_data_valid             (coeff_valid),
    .coeff_data                   (coeff_axi),
    .compute                      (compute),
    .input_data_valid             (x_valid),
    .input_data                   (x_axi),
    .output_data                  (out_data),
    .output_data_valid            (out_valid),
    .coefficient_loading_complete (loaded)
  );

endmodule

// File: tb/tb_fir_control_unit.sv
// Directed plus randomized bench for fir_control_unit against a queue-based FIR reference model.
module tb_fir_control_unit;
  import fir_pkg::*;

  localparam int MT = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] control_axi = '0, tap_count_axi = '0, coeff_axi = '0, x_axi = '0;
  logic        S_AXI_AWREADY = 1'b0, S_AXI_AWVALID = 1'b0;
  logic [31:0] S_AXI_AWADDR = '0;
  logic [31:0] status_axi, y_axi;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          m_taps;
  int          m_coeff [MT];
  int          m_idx;
  bit          m_loaded, m_compute, m_ready;
  int          m_hist [$];
  logic [31:0] m_y;

  fir_control_unit #(.MAX_TAPS(MT)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .control_axi   (control_axi),
    .tap_count_axi (tap_count_axi),
    .coeff_axi     (coeff_axi),
    .x_axi         (x_axi),
    .status_axi    (status_axi),
    .y_axi         (y_axi),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWADDR  (S_AXI_AWADDR)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    m_taps = 0; m_idx = 0; m_loaded = 0; m_compute = 0; m_ready = 0; m_y = '0;
    m_hist.delete();
    for (int i = 0; i < MT; i++) begin
      m_hist.push_back(0);
      m_coeff[i] = 0;
    end
  endfunction

  function automatic logic [31:0] m_fir();
    longint acc;
    acc = 0;
    for (int i = 0; i < m_taps; i++) acc += longint'(m_coeff[i]) * longint'(m_hist[i]);
`ifdef FIR_SATURATE_EN
    if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (acc < -64'sd2147483648) return 32'h8000_0000;
`endif
    return acc[31:0];
  endfunction

  function automatic bit m_write(input logic [31:0] a, input logic [31:0] v);
    bit took;
    took = 0;
    case (a)
      ADDR_CONTROL: begin
        m_compute = v[0];
        if (v[1]) begin m_idx = 0; m_loaded = 0; end
      end
      ADDR_TAP_COUNT: begin
        m_taps = (v == 0) ? 1 : (v > 32'(MT)) ? MT : int'(v);
        m_idx = 0; m_loaded = 0;
      end
      ADDR_COEFF: if (!m_loaded && m_idx < MT) begin
        m_coeff[m_idx] = int'(v);
        m_idx++;
        if (m_idx == m_taps) m_loaded = 1;
      end
      ADDR_X: if (m_compute && m_loaded) begin
        m_hist.push_front(int'(v));
        void'(m_hist.pop_back());
        m_y = m_fir();
        m_ready = 1;
        took = 1;
      end
      default: ;
    endcase
    return took;
  endfunction

  function automatic logic [31:0] m_status();
    return {29'd0, m_compute, m_ready, m_loaded};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge following the edge that acts on the write.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] v, output bit took);
    @(negedge clk);
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1; S_AXI_AWREADY = 1'b1;
    case (a)
      ADDR_CONTROL:   control_axi = v;
      ADDR_TAP_COUNT: tap_count_axi = v;
      ADDR_COEFF:     coeff_axi = v;
      default:        x_axi = v;
    endcase
    @(negedge clk);
    S_AXI_AWVALID = 1'b0; S_AXI_AWREADY = 1'b0;
    took = m_write(a, v);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v, input string tag);
    bit took;
    bus_write(a, v, took);
    check({tag, " status"}, status_axi, m_status());
    check({tag, " y"}, y_axi, m_y);
  endtask

  task automatic wr_x(input logic [31:0] v, input string tag);
    bit took;
    bus_write(ADDR_X, v, took);
    check({tag, " valid@t+1"}, 32'(dut.out_valid), 32'd0);
    @(negedge clk);
    check({tag, " valid@t+2"}, 32'(dut.out_valid), 32'(took));
    @(negedge clk);
    check({tag, " y"}, y_axi, m_y);
    check({tag, " status"}, status_axi, m_status());
  endtask

  initial begin
    logic [31:0] ramp_y [10];
    bit          took;
    ramp_y = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd15, 32'd21, 32'd28, 32'd36, 32'd44, 32'd52};
    m_reset();

    repeat (2) @(negedge clk);
    check("reset status", status_axi, 32'd0);
    check("reset y", y_axi, 32'd0);
    rstn = 1'b1;

    // Load eight unit coefficients; a ninth must be dropped.
    wr(ADDR_TAP_COUNT, 32'd8, "taps8");
    wr(ADDR_CONTROL, 32'h2, "load start");
    for (int i = 0; i < 8; i++) begin
      wr(ADDR_COEFF, 32'd1, "coeff unit");
      if (i == 6) check("not loaded after 7", 32'(status_axi[STAT_LOADED]), 32'd0);
    end
    check("loaded after 8", 32'(status_axi[STAT_LOADED]), 32'd1);
    wr(ADDR_COEFF, 32'd5, "coeff extra");

    wr(ADDR_CONTROL, 32'h1, "compute on");
    for (int i = 0; i < 10; i++) begin
      wr_x(32'(i + 1), "ramp");
      check("ramp y table", y_axi, ramp_y[i]);
    end

    wr(ADDR_CONTROL, 32'h0, "compute off");
    wr_x(32'd99, "x while idle");
    check("y held idle", y_axi, 32'd52);
    wr(ADDR_CONTROL, 32'h3, "reload+compute");
    wr_x(32'd77, "x while loading");
    check("y held loading", y_axi, 32'd52);

    // Clamp to one tap.
    wr(ADDR_TAP_COUNT, 32'd0, "taps0");
    wr(ADDR_COEFF, 32'd3, "coeff3");
    check("one tap loaded", 32'(status_axi[STAT_LOADED]), 32'd1);
    wr(ADDR_CONTROL, 32'h1, "compute on 2");
    wr_x(32'd5, "x5");
    check("y 15", y_axi, 32'd15);
    wr_x(32'd7, "x7");
    check("y 21", y_axi, 32'd21);

    // Clamp to sixteen taps.
    wr(ADDR_TAP_COUNT, 32'd40, "taps40");
    for (int i = 0; i < 16; i++) begin
      wr(ADDR_COEFF, 32'($urandom_range(0, 20)) - 32'd10, "coeff16");
      if (i == 14) check("not loaded after 15", 32'(status_axi[STAT_LOADED]), 32'd0);
    end
    check("loaded after 16", 32'(status_axi[STAT_LOADED]), 32'd1);
    for (int i = 0; i < 4; i++) wr_x(32'($urandom_range(0, 1000)), "x16");

    // Overflow behaviour.
    wr(ADDR_TAP_COUNT, 32'd1, "taps1");
    wr(ADDR_COEFF, 32'h4000_0000, "coeff big");
    wr_x(32'd4, "x big pos");
`ifdef FIR_SATURATE_EN
    check("sat pos", y_axi, 32'h7FFF_FFFF);
`else
    check("wrap pos", y_axi, 32'h0000_0000);
`endif
    wr_x(32'hFFFF_FFFC, "x big neg");
`ifdef FIR_SATURATE_EN
    check("sat neg", y_axi, 32'h8000_0000);
`else
    check("wrap neg", y_axi, 32'h0000_0000);
`endif

    // Address without AWREADY, and an unmapped address, must do nothing.
    @(negedge clk);
    S_AXI_AWADDR = ADDR_X; S_AXI_AWVALID = 1'b1; x_axi = 32'd123;
    @(negedge clk);
    S_AXI_AWVALID = 1'b0;
    repeat (3) @(negedge clk);
    check("no ready y", y_axi, m_y);
    check("no ready status", status_axi, m_status());
    wr(32'h0000_0004, 32'd55, "unmapped 04");
    wr(32'h0000_0014, 32'd56, "unmapped 14");

    // Randomized load/stream rounds.
    for (int r = 0; r < 6; r++) begin
      int extra;
      if (r == 3) wr(ADDR_TAP_COUNT, $urandom, "rnd taps raw");
      else wr(ADDR_TAP_COUNT, 32'($urandom_range(1, MT)), "rnd taps");
      wr(ADDR_CONTROL, {30'd0, 1'b1, 1'($urandom_range(0, 1))}, "rnd load");
      extra = $urandom_range(0, 2);
      for (int i = 0; i < m_taps + extra; i++) begin
        if (r[0]) wr(ADDR_COEFF, $urandom, "rnd coeff");
        else wr(ADDR_COEFF, 32'($urandom_range(0, 200)) - 32'd100, "rnd coeff");
      end
      wr(ADDR_CONTROL, 32'h1, "rnd compute");
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 5) == 0) wr(ADDR_CONTROL, 32'(m_compute ? 0 : 1), "rnd toggle");
        if (r[0]) wr_x($urandom, "rnd x");
        else wr_x(32'($urandom_range(0, 2000)) - 32'd1000, "rnd x");
      end
    end

    // Asynchronous reset while a result is in flight.
    wr(ADDR_CONTROL, 32'h1, "pre-reset compute");
    bus_write(ADDR_X, 32'd11, took);
    #2 rstn = 1'b0;
    #1;
    m_reset();
    check("async rst status", status_axi, 32'd0);
    check("async rst y", y_axi, 32'd0);
    @(negedge clk);
    check("rst no valid", 32'(dut.out_valid), 32'd0);
    check("rst y held", y_axi, 32'd0);
    rstn = 1'b1;
    wr(ADDR_CONTROL, 32'h1, "post-rst compute");
    wr_x(32'd9, "post-rst x rejected");
    wr(ADDR_TAP_COUNT, 32'd2, "post-rst taps");
    wr(ADDR_COEFF, 32'd2, "post-rst c0");
    wr(ADDR_COEFF, 32'd3, "post-rst c1");
    wr_x(32'd10, "post-rst x10");
    check("post-rst y 20", y_axi, 32'd20);
    wr_x(32'd1, "post-rst x1");
    check("post-rst y 32", y_axi, 32'd32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_control_unit.md
Name: fir_control_unit

Overview:
- Memory-mapped FIR filter engine.
- Snoops an AXI-Lite write-address handshake plus mirrored register values, and decodes writes to tap-count, control, coefficient and sample registers.
- Loads coefficients and streams samples into the internal sub-module fir_datapath.
- Returns each filtered output and a status word to the register file.

Parameters:
- MAX_TAPS, 16, maximum filter length; sizes the coefficient and delay-line arrays.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- control_axi  in  32  control register value; bit0 compute enable, bit1 coefficient-load start.
- tap_count_axi  in  32  requested tap count.
- coeff_axi  in  32  signed coefficient word.
- x_axi  in  32  signed input sample.
- status_axi  out  32  status word (see Behaviour).
- y_axi  out  32  last filter output.
- S_AXI_AWREADY  in  1  AXI write-address ready (snooped).
- S_AXI_AWVALID  in  1  AXI write-address valid (snooped).
- S_AXI_AWADDR  in  32  AXI write address (snooped).

Behaviour:
- Reset values: all outputs 0; all internal state cleared (tap_count, coefficients, delay line, indices, flags).
- Write event: AWVALID && AWREADY at edge t latches the address.
- At edge t+1 the matching *_axi input is sampled and acted on, one action per cycle. Holding the handshake N cycles gives N consecutive samples.
- Address map:
  - 0x00 control
  - 0x08 tap_count
  - 0x0C coeff
  - 0x10 x
  - Any other address is ignored.
- Tap count:
  - tap_count = tap_count_axi clamped to 1..MAX_TAPS.
  - Writing it clears coefficient_loading_complete and the coefficient index.
- Control write with bit1=1: coefficient index ← 0, loading-complete ← 0.
- compute = control bit0, registered.
- Coefficient write:
  - Accepted only while loading is incomplete; pulses coeff_data_valid for 1 cycle.
  - The datapath stores it at coeff[index], then index++.
  - When index reaches tap_count, coefficient_loading_complete ← 1.
  - Further coefficient writes are dropped until a new load start.
- Sample write:
  - Accepted only if compute=1 and loading is complete; otherwise dropped with no state change.
  - Pulses x_data_valid for 1 cycle.
- Datapath on x_data_valid:
  - Shifts the delay line: d[0] ← x, d[i] ← d[i-1].
  - Next edge: output_data = Σ_{i<tap_count} coeff[i]·d[i], signed, accumulated at 64 bits and truncated to 32 bits (wraps).
  - output_data_valid pulses for 1 cycle.
  - Latency: sample write edge t → output valid at t+2.
- y_axi: updated to output_data on output_data_valid and held otherwise.
- status_axi:
  - bit0 coefficient_loading_complete
  - bit1 sticky output-ready, set on output_data_valid and cleared on the next accepted sample
  - bit2 compute
  - other bits 0
- Simultaneous events: the new handshake latches while the previous one is acted on; this supports back-to-back streams.
- Mid-operation control change: clearing bit0 blocks further samples; the delay line is kept.
- Reset mid-operation clears everything immediately (asynchronous).

Optional Feature:
- Macro FIR_SATURATE_EN.
- Defined: the 64-bit sum is saturated to 0x7FFFFFFF / 0x80000000 when it exceeds the signed 32-bit range.
- Undefined: low 32 bits are taken (wrap).

Decomposition:
- Package fir_pkg: register address constants (0x00/0x08/0x0C/0x10), control and status bit indices, default MAX_TAPS.
- Sub-module fir_datapath:
  - Contains the coefficient RAM/regs, delay line, multiply-accumulate and loading-complete flag.
  - Interface: tap_count, input_data_valid/input_data, coeff_data_valid/coeff_data, compute, output_data/output_data_valid, coefficient_loading_complete.
- fir_control_unit: address decode, clamping, gating and status/y registers.

Test Plan:
- Write tap_count=8, control=0x2, then 8 coeff writes of 1 -> status bit0=1 after the 8th; a 9th coeff write is ignored.
- Coefficients all 1, control=0x1, samples 1..10 -> y_axi = 1, 3, 6, 10, 15, 21, 28, 36, 44, 52, each valid 2 cycles after its write.
- Sample written with control=0x0 or before loading completes -> no output_data_valid; y_axi unchanged.
- tap_count_axi=0 -> 1; tap_count_axi=40 -> 16. After the clamp to 1, coefficient {3} and samples 5, 7 -> y_axi = 15, 21.
- Coefficient 0x40000000, sample 4 -> wrap gives 0; with FIR_SATURATE_EN gives 0x7FFFFFFF.
- Assert rstn low mid-stream -> all outputs 0 at once; status 0; samples rejected until coefficients are reloaded.
